// File: rtl/compare_seq_nb.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK-bit slice per
// cycle from the most significant end and stops at the first differing slice.
module compare_seq_nb #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                signed_mode,
   input  logic [WIDTH-1:0]                    A,
   input  logic [WIDTH-1:0]                    B,
   output logic                                busy,
   output logic                                done,
   output logic                                A_gt_B,
   output logic                                A_lt_B,
   output logic                                A_eq_B,
   output logic [$clog2(WIDTH/CHUNK):0]        chunks_used
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N) + 1;
   localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, CMP = 1'b1} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_signed;
   logic [IW-1:0]     r_idx;
   logic              r_busy;
   logic              r_done;
   logic              r_gt;
   logic              r_lt;
   logic              r_eq;
   logic [CW-1:0]     r_chunks;

   logic [CHUNK-1:0]  w_sa;
   logic [CHUNK-1:0]  w_sb;
   logic [CHUNK-1:0]  w_flip;
   logic [CW-1:0]     w_chunks;

   // Slice mux; in signed mode the top slice has its sign bit inverted so an
   // unsigned compare of that slice orders negatives below positives.
   always_comb begin
      w_sa = '0;
      w_sb = '0;
      for (int i = 0; i < N; i++) begin
         if (r_idx == IW'(i)) begin
            w_sa = r_a[i*CHUNK +: CHUNK];
            w_sb = r_b[i*CHUNK +: CHUNK];
         end else begin
            w_sa = w_sa;
            w_sb = w_sb;
         end
      end
      if (r_signed && (r_idx == IW'(N - 1))) begin
         w_flip = MSB_MASK;
      end else begin
         w_flip = '0;
      end
      w_sa     = w_sa ^ w_flip;
      w_sb     = w_sb ^ w_flip;
      w_chunks = CW'(N) - CW'(r_idx);
   end

   // Control FSM and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
         r_eq     <= 1'b0;
         r_chunks <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_signed <= signed_mode;
                  r_idx    <= IW'(N - 1);
                  r_busy   <= 1'b1;
                  r_state  <= CMP;
               end else begin
                  r_state  <= IDLE;
               end
            end
            CMP: begin
               if (w_sa != w_sb) begin
                  r_gt     <= (w_sa > w_sb);
                  r_lt     <= (w_sa < w_sb);
                  r_eq     <= 1'b0;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_chunks <= w_chunks;
                  r_state  <= IDLE;
               end else if (r_idx == IW'(0)) begin
                  r_gt     <= 1'b0;
                  r_lt     <= 1'b0;
                  r_eq     <= 1'b1;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_chunks <= CW'(N);
                  r_state  <= IDLE;
               end else begin
                  r_idx    <= r_idx - IW'(1);
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign A_gt_B      = r_gt;
   assign A_lt_B      = r_lt;
   assign A_eq_B      = r_eq;
   assign chunks_used = r_chunks;

endmodule

// File: tb/tb_compare_seq_nb.sv
// Directed bench for compare_seq_nb (WIDTH=32, CHUNK=8): vector table plus
// hand-written handshake, back-to-back and reset-abort sequences.
module tb_compare_seq_nb;

   logic        clk;
   logic        rst;
   logic        start;
   logic        signed_mode;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        A_gt_B;
   logic        A_lt_B;
   logic        A_eq_B;
   logic [2:0]  chunks_used;

   int n_cmp  = 0;
   int n_fail = 0;

   compare_seq_nb #(.WIDTH(32), .CHUNK(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .A_gt_B      (A_gt_B),
      .A_lt_B      (A_lt_B),
      .A_eq_B      (A_eq_B),
      .chunks_used (chunks_used)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sm;
      logic        gt;
      logic        lt;
      logic        eq;
      int          k;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Waits up to 12 edges for done; c=0 means it never came.
   task automatic wait_done(output int c, output bit busy_ok);
      c = 0;
      busy_ok = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            c = i;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic check_result(input string tag, input int c, input int k,
                               input logic gt, input logic lt, input logic eq);
      check({tag, "_latency"}, 32'(c), 32'(k));
      check({tag, "_gt"}, {31'd0, A_gt_B}, {31'd0, gt});
      check({tag, "_lt"}, {31'd0, A_lt_B}, {31'd0, lt});
      check({tag, "_eq"}, {31'd0, A_eq_B}, {31'd0, eq});
      check({tag, "_chunks"}, {29'd0, chunks_used}, 32'(k));
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int  c;
      int  ndone;
      bit  bok;

      vecs[0] = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, 4};
      vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      vecs[3] = '{32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b1, 1'b0, 4};
      vecs[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4};
      vecs[5] = '{32'h00120000, 32'h00110000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
      vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[8] = '{32'h1234AB00, 32'h1234CD00, 1'b1, 1'b0, 1'b1, 1'b0, 3};
      vecs[9] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 4};

      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_gt", {31'd0, A_gt_B}, 32'd0);
      check("rst_lt", {31'd0, A_lt_B}, 32'd0);
      check("rst_eq", {31'd0, A_eq_B}, 32'd0);
      check("rst_chunks", {29'd0, chunks_used}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         A = vecs[i].a; B = vecs[i].b; signed_mode = vecs[i].sm; start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         check($sformatf("v%0d_busy_after_start", i), {31'd0, busy}, 32'd1);
         wait_done(c, bok);
         check($sformatf("v%0d_busy_held", i), {31'd0, bok}, 32'd1);
         check_result($sformatf("v%0d", i), c, vecs[i].k, vecs[i].gt, vecs[i].lt, vecs[i].eq);
      end

      // Second start and changed operands mid-compare must not disturb the result.
      @(negedge clk);
      A = 32'h00000005; B = 32'h00000003; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("hs_ignore_nodone_e1", {31'd0, done}, 32'd0);
      start = 1'b1; A = 32'h00000000; B = 32'hFFFFFFFF; signed_mode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(c, bok);
      check_result("hs_ignore", c + 2, 4, 1'b1, 1'b0, 1'b0);

      // Start raised during the done cycle is accepted.
      @(negedge clk);
      A = 32'h80000000; B = 32'h00000000; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(c, bok);
      check_result("hs_first", c, 1, 1'b1, 1'b0, 1'b0);
      A = 32'h00000000; B = 32'h00000001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hs_done_cycle_busy", {31'd0, busy}, 32'd1);
      check("hs_done_cycle_done", {31'd0, done}, 32'd0);
      wait_done(c, bok);
      check_result("hs_second", c, 4, 1'b0, 1'b1, 1'b0);

      // Start held high with a 1-slice compare: one result every 2 cycles.
      @(negedge clk);
      A = 32'h80000000; B = 32'h00000000; signed_mode = 1'b0; start = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      start = 1'b0;
      check("b2b_done_count", 32'(ndone), 32'd4);
      @(posedge clk); #1;
      check("b2b_last_gt", {31'd0, A_gt_B}, 32'd1);

      // Reset at the second CMP edge, with start also high, aborts cleanly.
      @(negedge clk);
      A = 32'h00000007; B = 32'h00000007; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_done", {31'd0, done}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      check("rstmid_no_done", 32'(ndone), 32'd0);
      check("rstmid_gt", {31'd0, A_gt_B}, 32'd0);
      check("rstmid_eq", {31'd0, A_eq_B}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
